// File: rtl/score_display.sv
// score_display: reader of the 32-bit score bus driving an 8-digit multiplexed
// seven-segment display.
//   Decimal mode: a sequential double-dabble engine converts the score to BCD,
//   saturating the shown value at 99,999,999.
//   Hex mode: the raw nibbles of the score are shown.
//   A free-running refresh counter scans the digits; leading zeros can be blanked.
// Ports:
//   clk      - system clock
//   reset    - synchronous active-high reset
//   value    - unsigned score to display
//   hex_mode - 1 = raw hex nibbles, 0 = decimal
//   busy     - high while a BCD conversion is in progress
//   an       - digit enables, active-low, an[0] is the rightmost digit
//   cat      - segments {g,f,e,d,c,b,a}, active-low
module score_display #(
   parameter int unsigned REFRESH_BITS  = 17,
   parameter bit          BLANK_LEADING = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] value,
   input  logic        hex_mode,
   output logic        busy,
   output logic [7:0]  an,
   output logic [6:0]  cat
);

   localparam int unsigned VALUE_W  = 32;
   localparam int unsigned NDIGITS  = 8;
   localparam int unsigned SEL_W    = 3;
   localparam int unsigned BITCNT_W = 5;

   localparam logic [VALUE_W-1:0] DEC_MAX = VALUE_W'(99_999_999);
   localparam logic [VALUE_W-1:0] SAT_BCD = 32'h9999_9999;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t                   state;
   logic [VALUE_W-1:0]       captured;
   logic [VALUE_W-1:0]       bin_sr;
   logic [VALUE_W-1:0]       bcd_sr;
   logic [VALUE_W-1:0]       digits;
   logic                     sat;
   logic [BITCNT_W-1:0]      bit_cnt;

   logic [VALUE_W-1:0]       hex_src;
   logic                     hex_sel;
   logic [REFRESH_BITS-1:0]  refresh;

   logic [VALUE_W-1:0]       src_c;
   logic [SEL_W-1:0]         sel_c;
   logic [3:0]               nib_c;
   logic                     blank_c;
   logic [NDIGITS-1:0]       an_c;
   logic [6:0]               cat_c;

   // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
   function automatic logic [VALUE_W-1:0] dabble(input logic [VALUE_W-1:0] b);
      logic [VALUE_W-1:0] r;
      r = b;
      for (int i = 0; i < int'(NDIGITS); i++) begin
         if (b[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = b[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   // Nibble to active-low {g,f,e,d,c,b,a} segment pattern.
   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Conversion FSM: capture on change, 32 shift cycles, then commit.
   // Changes on value during SHIFT/COMMIT are picked up on return to IDLE
   // because the new value then differs from the captured one.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         captured <= '0;
         bin_sr   <= '0;
         bcd_sr   <= '0;
         digits   <= '0;
         sat      <= 1'b0;
         bit_cnt  <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (value != captured) begin
                  captured <= value;
                  bin_sr   <= value;
                  sat      <= (value > DEC_MAX);
                  bcd_sr   <= '0;
                  bit_cnt  <= BITCNT_W'(31);
                  busy     <= 1'b1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               // bin_sr starts as the captured value, so its MSB feeds the BCD side.
               {bcd_sr, bin_sr} <= {dabble(bcd_sr), bin_sr} << 1;
               bit_cnt          <= bit_cnt - BITCNT_W'(1);
               if (bit_cnt == '0) begin
                  state <= COMMIT;
               end
            end
            COMMIT: begin
               digits <= sat ? SAT_BCD : bcd_sr;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Display source selection, digit scan and blanking.
   always_comb begin
      src_c   = hex_sel ? hex_src : digits;
      sel_c   = refresh[REFRESH_BITS-1 -: SEL_W];
      nib_c   = src_c[{sel_c, 2'b00} +: 4];
      // Digits sel..7 are all zero exactly when the source shifted down by sel nibbles is zero.
      blank_c = BLANK_LEADING && (sel_c != '0) &&
                ((src_c >> {sel_c, 2'b00}) == '0);
      an_c    = blank_c ? 8'hFF : ~(8'b1 << sel_c);
      cat_c   = seg_decode(nib_c);
   end

   // Hex source, mode register, refresh counter and registered display outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         hex_src <= '0;
         hex_sel <= 1'b0;
         refresh <= '0;
         an      <= 8'hFF;
         cat     <= 7'h7F;
      end else begin
         hex_src <= value;
         hex_sel <= hex_mode;
         refresh <= refresh + REFRESH_BITS'(1);
         an      <= an_c;
         cat     <= cat_c;
      end
   end

endmodule

// File: tb/tb_score_display.sv
// tb_score_display: table-driven display checks, hand-written multi-cycle
// sequences and randomized traffic compared cycle by cycle against a
// behavioural model of the display (decimal arithmetic, no BCD engine).
module tb_score_display;

   localparam int unsigned RB = 5;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] value;
   logic        hex_mode;
   logic        busy, busy_nb;
   logic [7:0]  an, an_nb;
   logic [6:0]  cat, cat_nb;

   int tests = 0;
   int fails = 0;

   score_display #(.REFRESH_BITS(RB), .BLANK_LEADING(1'b1)) dut (
      .clk(clk), .reset(reset), .value(value), .hex_mode(hex_mode),
      .busy(busy), .an(an), .cat(cat)
   );

   score_display #(.REFRESH_BITS(RB), .BLANK_LEADING(1'b0)) dut_nb (
      .clk(clk), .reset(reset), .value(value), .hex_mode(hex_mode),
      .busy(busy_nb), .an(an_nb), .cat(cat_nb)
   );

   always #5 clk = ~clk;

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // ---------------- behavioural model ----------------
   int          m_cnt   = 0;
   logic [31:0] m_cap   = '0;
   int          m_left  = 0;
   longint      m_shown = 0;
   logic [31:0] m_hex   = '0;
   logic        m_mode  = 1'b0;
   logic [3:0]  md [8];
   int          msel, mtop;
   longint      p10;
   logic [7:0]  exp_an     = 8'hFF;
   logic [6:0]  exp_cat    = 7'h7F;
   logic [7:0]  exp_an_nb  = 8'hFF;
   logic [6:0]  exp_cat_nb = 7'h7F;
   logic        exp_busy   = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_cnt = 0; m_cap = '0; m_left = 0; m_shown = 0; m_hex = '0; m_mode = 1'b0;
         exp_an = 8'hFF; exp_cat = 7'h7F; exp_an_nb = 8'hFF; exp_cat_nb = 7'h7F;
         exp_busy = 1'b0;
      end else begin
         // Outputs come from the state before this edge.
         msel = (m_cnt / 4) % 8;
         p10  = 1;
         mtop = 0;
         for (int i = 0; i < 8; i++) begin
            md[i] = m_mode ? m_hex[4*i +: 4] : 4'((m_shown / p10) % 10);
            p10   = p10 * 10;
            if (md[i] != 4'd0) mtop = i;
         end
         exp_an_nb  = ~(8'b1 << msel);
         exp_an     = (msel > mtop) ? 8'hFF : exp_an_nb;
         exp_cat    = seg_tab[md[msel]];
         exp_cat_nb = seg_tab[md[msel]];
         m_cnt = (m_cnt + 1) % 32;
         // Conversion: 1 capture edge, then 33 more edges until the result is shown.
         if (m_left == 0) begin
            if (value != m_cap) begin
               m_cap  = value;
               m_left = 33;
            end
         end else begin
            m_left = m_left - 1;
            if (m_left == 0) m_shown = (m_cap > 32'd99_999_999) ? 64'd99_999_999 : longint'(m_cap);
         end
         exp_busy = (m_left != 0);
         m_hex  = value;
         m_mode = hex_mode;
      end
   end

   // One cycle: wait for the falling edge, compare against the model.
   task automatic step();
      @(negedge clk);
      tests++;
      if (busy !== exp_busy || busy_nb !== exp_busy) begin
         fails++;
         $display("FAIL busy t=%0t: got %b/%b expected %b", $time, busy, busy_nb, exp_busy);
      end
      tests++;
      if (an !== exp_an) begin
         fails++;
         $display("FAIL an t=%0t: got %h expected %h", $time, an, exp_an);
      end
      if (exp_an != 8'hFF) begin
         tests++;
         if (cat !== exp_cat) begin
            fails++;
            $display("FAIL cat t=%0t: got %h expected %h", $time, cat, exp_cat);
         end
      end
      tests++;
      if (an_nb !== exp_an_nb || cat_nb !== exp_cat_nb) begin
         fails++;
         $display("FAIL an/cat noblank t=%0t: got %h/%h expected %h/%h",
                  $time, an_nb, cat_nb, exp_an_nb, exp_cat_nb);
      end
   endtask

   // Scan one full refresh period; 7F marks a digit that was never lit.
   task automatic collect(output logic [7:0][6:0] got, output logic [7:0][6:0] got_nb);
      got    = {8{7'h7F}};
      got_nb = {8{7'h7F}};
      for (int k = 0; k < 32; k++) begin
         step();
         for (int j = 0; j < 8; j++) begin
            if (an[j] == 1'b0)    got[j]    = cat;
            if (an_nb[j] == 1'b0) got_nb[j] = cat_nb;
         end
      end
   endtask

   // Compare both instances against the expected blanked pattern; the
   // non-blanking instance shows "0" wherever the other is dark.
   task automatic check_display(input string name, input logic [7:0][6:0] expd);
      logic [7:0][6:0] got, got_nb, exp_nb;
      collect(got, got_nb);
      for (int j = 0; j < 8; j++) begin
         exp_nb[j] = (expd[j] == 7'h7F) ? 7'h40 : expd[j];
         tests++;
         if (got[j] !== expd[j]) begin
            fails++;
            $display("FAIL %s digit %0d: cat got %h expected %h", name, j, got[j], expd[j]);
         end
         tests++;
         if (got_nb[j] !== exp_nb[j]) begin
            fails++;
            $display("FAIL %s noblank digit %0d: cat got %h expected %h", name, j, got_nb[j], exp_nb[j]);
         end
      end
   endtask

   typedef struct {
      logic [31:0]     value;
      logic            hex;
      logic [7:0][6:0] cats;   // {d7..d0}, 7F = blanked
   } vec_t;

   vec_t tbl [13];
   int   hi;
   int   r;

   initial begin
      #1_000_000;
      fails++;
      $display("FAIL timeout: bench did not complete within the time limit");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      tbl[0]  = '{32'd0,           1'b0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h40}};
      tbl[1]  = '{32'd1234,        1'b0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h79,7'h24,7'h30,7'h19}};
      tbl[2]  = '{32'd123_456_789, 1'b0, {8{7'h10}}};
      tbl[3]  = '{32'h00C0FFEE,    1'b1, {7'h7F,7'h7F,7'h46,7'h40,7'h0E,7'h0E,7'h06,7'h06}};
      tbl[4]  = '{32'd99_999_999,  1'b0, {8{7'h10}}};
      tbl[5]  = '{32'd100_000_000, 1'b0, {8{7'h10}}};
      tbl[6]  = '{32'd10_000_000,  1'b0, {7'h79,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40}};
      tbl[7]  = '{32'hFFFFFFFF,    1'b1, {8{7'h0E}}};
      tbl[8]  = '{32'h00000010,    1'b1, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h79,7'h40}};
      tbl[9]  = '{32'h0000A5B0,    1'b1, {7'h7F,7'h7F,7'h7F,7'h7F,7'h08,7'h12,7'h03,7'h40}};
      tbl[10] = '{32'd987,         1'b0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h10,7'h00,7'h78}};
      tbl[11] = '{32'd6,           1'b0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h02}};
      tbl[12] = '{32'h000D0000,    1'b1, {7'h7F,7'h7F,7'h7F,7'h21,7'h40,7'h40,7'h40,7'h40}};

      reset = 1'b1; value = '0; hex_mode = 1'b0;
      repeat (3) step();
      tests++;
      if (an !== 8'hFF || cat !== 7'h7F || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: an=%h cat=%h busy=%b expected FF/7F/0", an, cat, busy);
      end
      reset = 1'b0;

      // Table-driven display checks.
      for (int t = 0; t < 13; t++) begin
         value    = tbl[t].value;
         hex_mode = tbl[t].hex;
         repeat (80) step();
         check_display($sformatf("vec%0d", t), tbl[t].cats);
      end

      // Busy rises one cycle after a change and stays high 33 cycles.
      hex_mode = 1'b0;
      value    = 32'd4321;
      step();
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL busy_rise: got %b expected 1", busy);
      end
      hi = 1;
      for (int k = 0; k < 60; k++) begin
         step();
         if (busy !== 1'b1) break;
         hi++;
      end
      tests++;
      if (hi != 33) begin
         fails++;
         $display("FAIL busy_width: got %0d cycles expected 33", hi);
      end
      repeat (5) step();

      // 10 -> 20 -> 30 on consecutive cycles: 10 is shown first, then 30.
      value = 32'd10; step();
      value = 32'd20; step();
      value = 32'd30; step();
      hi = 0;
      for (int k = 0; k < 50; k++) begin
         if (busy === 1'b0) break;
         step();
         hi++;
      end
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL busy_fall_wait: busy still %b after %0d cycles", busy, hi);
      end
      step();
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL reconvert_start: busy got %b expected 1", busy);
      end
      check_display("seq_ten", {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h79,7'h40});
      repeat (10) step();
      check_display("seq_thirty", {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h30,7'h40});

      // Reset at shift 15 of converting 5000.
      value = 32'd5000;
      step();
      repeat (15) step();
      reset = 1'b1;
      step();
      tests++;
      if (busy !== 1'b0 || an !== 8'hFF || cat !== 7'h7F) begin
         fails++;
         $display("FAIL mid_reset: busy=%b an=%h cat=%h expected 0/FF/7F", busy, an, cat);
      end
      reset = 1'b0;
      check_display("post_reset_zero", {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h40});
      repeat (10) step();
      check_display("post_reset_5000", {7'h7F,7'h7F,7'h7F,7'h7F,7'h12,7'h40,7'h40,7'h40});

      // Randomized traffic, checked every cycle against the model.
      for (int it = 0; it < 250; it++) begin
         r = int'($urandom_range(0, 9));
         if (r < 5) begin
            case ($urandom_range(0, 3))
               0:       value = $urandom;
               1:       value = $urandom_range(0, 9999);
               2:       value = $urandom_range(99_999_990, 100_000_010);
               default: value = value + 32'd1;
            endcase
         end else if (r < 7) begin
            hex_mode = ~hex_mode;
         end else if (r == 7) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
         end
         repeat ($urandom_range(1, 45)) step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
